// File: rtl/vga_dls_recovery_ctrl.sv
// Lockstep VGA recovery controller: resets the VGA pair on a DLS mismatch, gives up after MAX_RETRY tries.
// Optional build macro DLS_IRQ_EN enables the sticky fault interrupt; without it IRQ is tied low.
module vga_dls_recovery_ctrl #(
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned RESYNC_CYCLES = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        DLS_ERROR,
    output logic        VGA_RSTn,
    output logic        FAULT,
    output logic        IRQ
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_HOLD   = 3'd2,
        S_SETTLE = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [7:0] HOLD_LAST   = 8'(RESYNC_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'd1;

    // AHB data-phase bookkeeping
    logic       dp_vld_q, dp_vld_d;
    logic       dp_wr_q,  dp_wr_d;
    logic [1:0] dp_addr_q, dp_addr_d;

    logic       en_q, en_d;
    state_t     state_q, state_d;
    logic [3:0] retry_q, retry_d;
    logic [7:0] err_q, err_d;
    logic [7:0] hold_q, hold_d;
    logic       irq_q, irq_d;
    logic       vga_rstn_q, fault_q;

    logic       wr_fire, ctrl_wr, clr;
    logic [31:0] status;

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:2], HTRANS[0]};

    assign HREADYOUT = 1'b1;

    always_comb begin
        dp_vld_d  = dp_vld_q;
        dp_wr_d   = dp_wr_q;
        dp_addr_d = dp_addr_q;
        if (HREADY) begin
            dp_vld_d  = HSEL & HTRANS[1];
            dp_wr_d   = HWRITE;
            dp_addr_d = HADDR[3:2];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld_q  <= 1'b0;
            dp_wr_q   <= 1'b0;
            dp_addr_q <= 2'd0;
        end else begin
            dp_vld_q  <= dp_vld_d;
            dp_wr_q   <= dp_wr_d;
            dp_addr_q <= dp_addr_d;
        end
    end

    assign wr_fire = dp_vld_q & dp_wr_q & HREADY;
    assign ctrl_wr = wr_fire & (dp_addr_q == 2'd1);
    assign clr     = ctrl_wr & HWDATA[1];
    assign en_d    = ctrl_wr ? HWDATA[0] : en_q;

    // CLR outranks EN=0, which outranks a mismatch
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        err_d   = err_q;
        hold_d  = hold_q;
        irq_d   = irq_q;
        if (clr) begin
            state_d = S_IDLE;
            retry_d = 4'd0;
            err_d   = 8'd0;
            hold_d  = 8'd0;
            irq_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_q) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!en_q) begin
                        state_d = S_IDLE;
                    end else if (DLS_ERROR) begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = S_FAULT;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            hold_d  = 8'd0;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!en_q) begin
                        state_d = S_IDLE;
                        hold_d  = 8'd0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = S_SETTLE;
                        hold_d  = 8'd0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (!en_q) begin
                        state_d = S_IDLE;
                        hold_d  = 8'd0;
                    end else if (hold_q == SETTLE_LAST) begin
                        state_d = S_RUN;
                        hold_d  = 8'd0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                S_FAULT: ;
                default: state_d = S_IDLE;
            endcase
`ifdef DLS_IRQ_EN
            if (state_d == S_FAULT && state_q != S_FAULT) irq_d = 1'b1;
`else
            irq_d = 1'b0;
`endif
        end
    end

    // Outputs follow state_d so they are registered yet aligned with state_q
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            retry_q    <= 4'd0;
            err_q      <= 8'd0;
            hold_q     <= 8'd0;
            irq_q      <= 1'b0;
            vga_rstn_q <= 1'b1;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            irq_q      <= irq_d;
            vga_rstn_q <= !(state_d == S_HOLD || state_d == S_FAULT);
            fault_q    <= (state_d == S_FAULT);
        end
    end

    assign VGA_RSTn = vga_rstn_q;
    assign FAULT    = fault_q;
    assign IRQ      = irq_q;

    assign status = {8'd0, err_q, 4'd0, retry_q, 3'd0, irq_q, fault_q, state_q};

    always_comb begin
        HRDATA = 32'd0;
        if (dp_vld_q && !dp_wr_q) begin
            case (dp_addr_q)
                2'd0:    HRDATA = status;
                2'd1:    HRDATA = {31'd0, en_q};
                default: HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_dls_recovery_ctrl.sv
// Directed bench for vga_dls_recovery_ctrl; the bus keeps polling STATUS so state is visible every cycle.
module tb_vga_dls_recovery_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        DLS_ERROR;
    logic        VGA_RSTn;
    logic        FAULT;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DLS_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    vga_dls_recovery_ctrl #(.MAX_RETRY(3), .RESYNC_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .DLS_ERROR(DLS_ERROR), .VGA_RSTn(VGA_RSTn),
        .FAULT(FAULT), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic step;
        @(negedge HCLK);
    endtask

    // write, then resume STATUS polling in the data phase
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge HCLK); HADDR = a; HWRITE = 1'b1;
        @(negedge HCLK); HWDATA = d; HADDR = 32'h0; HWRITE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge HCLK); HADDR = a;
        @(negedge HCLK); HADDR = 32'h0; d = HRDATA;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0; HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b0;
        HREADY = 1'b1; HWDATA = 32'h0; DLS_ERROR = 1'b0;
        repeat (3) step;
        n_checks++; if (VGA_RSTn !== 1'b1) begin n_fail++; $display("FAIL reset_vga: got %b want 1", VGA_RSTn); end
        n_checks++; if (FAULT !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", FAULT); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b want 1", HREADYOUT); end
        HRESETn = 1'b1;
        step;
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", HRDATA); end
    endtask

    task automatic test_enable;
        wr(32'h4, 32'h1);
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd0) begin n_fail++; $display("FAIL en_idle_first: state=%0d want 0", HRDATA[2:0]); end
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd1) begin n_fail++; $display("FAIL en_run: state=%0d want 1", HRDATA[2:0]); end
        n_checks++; if (HRDATA[3] !== 1'b0 || FAULT !== 1'b0 || VGA_RSTn !== 1'b1) begin
            n_fail++; $display("FAIL en_outs: fault=%b/%b vga=%b want 0/0/1", HRDATA[3], FAULT, VGA_RSTn); end
    endtask

    task automatic test_single_recovery;
        int n;
        DLS_ERROR = 1'b1;
        step;
        DLS_ERROR = 1'b0;
        n_checks++; if (HRDATA[2:0] !== 3'd2 || VGA_RSTn !== 1'b0) begin
            n_fail++; $display("FAIL rec_hold_entry: state=%0d vga=%b want 2/0", HRDATA[2:0], VGA_RSTn); end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (HRDATA[2:0] == 3'd2 && VGA_RSTn == 1'b0) n++;
            else break;
            step;
        end
        n_checks++; if (n !== 16) begin n_fail++; $display("FAIL rec_hold_len: got %0d want 16", n); end
        n_checks++; if (HRDATA[2:0] !== 3'd3 || VGA_RSTn !== 1'b1) begin
            n_fail++; $display("FAIL rec_settle1: state=%0d vga=%b want 3/1", HRDATA[2:0], VGA_RSTn); end
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd3) begin n_fail++; $display("FAIL rec_settle2: state=%0d want 3", HRDATA[2:0]); end
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd1) begin n_fail++; $display("FAIL rec_run: state=%0d want 1", HRDATA[2:0]); end
        n_checks++; if (HRDATA[11:8] !== 4'd1 || HRDATA[23:16] !== 8'd1) begin
            n_fail++; $display("FAIL rec_counters: retry=%0d err=%0d want 1/1", HRDATA[11:8], HRDATA[23:16]); end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        rd(32'h4, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL reg_ctrl_rd: got %h want 1", d); end
        rd(32'h8, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reg_0x8_rd: got %h want 0", d); end
        rd(32'hC, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reg_0xC_rd: got %h want 0", d); end
        wr(32'h8, 32'h2);
        wr(32'h0, 32'h0);
        step; step;
        n_checks++; if (HRDATA !== 32'h0001_0101) begin n_fail++; $display("FAIL reg_wr_ignored: status=%h want 00010101", HRDATA); end
    endtask

    task automatic test_retry_exhaust;
        int cyc, holds, bad;
        logic [2:0] prev, st;
        logic done;
        wr(32'h4, 32'h3);
        step;
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL ex_clr_from_run: status=%h want 0", HRDATA); end
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd1) begin n_fail++; $display("FAIL ex_run: state=%0d want 1", HRDATA[2:0]); end
        DLS_ERROR = 1'b1;
        prev = 3'd1; cyc = 0; holds = 0; bad = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            step;
            cyc++;
            st = HRDATA[2:0];
            if (st == 3'd2 && prev != 3'd2) holds++;
            if (FAULT != (st == 3'd4) || VGA_RSTn != !(st == 3'd2 || st == 3'd4)) bad++;
            if (st == 3'd4) done = 1'b1;
            prev = st;
        end
        DLS_ERROR = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ex_timeout: no FAULT within %0d cycles", cyc); end
        n_checks++; if (cyc !== 58) begin n_fail++; $display("FAIL ex_cycles: got %0d want 58", cyc); end
        n_checks++; if (holds !== 3) begin n_fail++; $display("FAIL ex_recoveries: got %0d want 3", holds); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ex_out_consistency: %0d bad cycles want 0", bad); end
        n_checks++; if (FAULT !== 1'b1 || VGA_RSTn !== 1'b0) begin
            n_fail++; $display("FAIL ex_fault_outs: fault=%b vga=%b want 1/0", FAULT, VGA_RSTn); end
        n_checks++; if (HRDATA[11:8] !== 4'd3 || HRDATA[23:16] !== 8'd4) begin
            n_fail++; $display("FAIL ex_counters: retry=%0d err=%0d want 3/4", HRDATA[11:8], HRDATA[23:16]); end
        n_checks++; if (IRQ !== IRQ_ON || HRDATA[4] !== IRQ_ON) begin
            n_fail++; $display("FAIL ex_irq: irq=%b pend=%b want %b", IRQ, HRDATA[4], IRQ_ON); end
    endtask

    task automatic test_fault_clear;
        wr(32'h4, 32'h0);
        step; step;
        n_checks++; if (HRDATA[2:0] !== 3'd4 || FAULT !== 1'b1 || VGA_RSTn !== 1'b0) begin
            n_fail++; $display("FAIL fc_en0_stays: state=%0d fault=%b vga=%b want 4/1/0", HRDATA[2:0], FAULT, VGA_RSTn); end
        wr(32'h4, 32'h3);
        step;
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL fc_clr_status: status=%h want 0", HRDATA); end
        n_checks++; if (FAULT !== 1'b0 || VGA_RSTn !== 1'b1 || IRQ !== 1'b0) begin
            n_fail++; $display("FAIL fc_clr_outs: fault=%b vga=%b irq=%b want 0/1/0", FAULT, VGA_RSTn, IRQ); end
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd1) begin n_fail++; $display("FAIL fc_run: state=%0d want 1", HRDATA[2:0]); end
    endtask

    task automatic test_clr_priority;
        wr(32'h4, 32'h3);
        DLS_ERROR = 1'b1;
        step;
        DLS_ERROR = 1'b0;
        n_checks++; if (HRDATA[2:0] !== 3'd0 || HRDATA[23:16] !== 8'd0 || HRDATA[11:8] !== 4'd0) begin
            n_fail++; $display("FAIL clr_prio: state=%0d err=%0d retry=%0d want 0/0/0", HRDATA[2:0], HRDATA[23:16], HRDATA[11:8]); end
        n_checks++; if (VGA_RSTn !== 1'b1) begin n_fail++; $display("FAIL clr_prio_vga: got %b want 1", VGA_RSTn); end
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd1) begin n_fail++; $display("FAIL clr_prio_run: state=%0d want 1", HRDATA[2:0]); end
    endtask

    task automatic test_en_abort;
        DLS_ERROR = 1'b1;
        step;
        DLS_ERROR = 1'b0;
        wr(32'h4, 32'h0);
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd2 || VGA_RSTn !== 1'b0) begin
            n_fail++; $display("FAIL abort_still_hold: state=%0d vga=%b want 2/0", HRDATA[2:0], VGA_RSTn); end
        step;
        n_checks++; if (HRDATA[2:0] !== 3'd0 || VGA_RSTn !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle: state=%0d vga=%b want 0/1", HRDATA[2:0], VGA_RSTn); end
        n_checks++; if (HRDATA[11:8] !== 4'd1 || HRDATA[23:16] !== 8'd1) begin
            n_fail++; $display("FAIL abort_retained: retry=%0d err=%0d want 1/1", HRDATA[11:8], HRDATA[23:16]); end
        wr(32'h4, 32'h1);
        step; step;
        n_checks++; if (HRDATA !== 32'h0001_0101) begin n_fail++; $display("FAIL abort_rerun: status=%h want 00010101", HRDATA); end
    endtask

    task automatic test_reset_mid_hold;
        logic [31:0] d;
        int low;
        DLS_ERROR = 1'b1;
        step;
        DLS_ERROR = 1'b0;
        repeat (4) step;
        n_checks++; if (HRDATA[2:0] !== 3'd2 || VGA_RSTn !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold5: state=%0d vga=%b want 2/0", HRDATA[2:0], VGA_RSTn); end
        HRESETn = 1'b0;
        #1;
        n_checks++; if (VGA_RSTn !== 1'b1 || FAULT !== 1'b0 || IRQ !== 1'b0 || HRDATA !== 32'h0) begin
            n_fail++; $display("FAIL rst_async: vga=%b fault=%b irq=%b hrdata=%h want 1/0/0/0", VGA_RSTn, FAULT, IRQ, HRDATA); end
        step; step;
        HRESETn = 1'b1;
        step;
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL rst_status: status=%h want 0", HRDATA); end
        rd(32'h4, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_en: ctrl=%h want 0", d); end
        low = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (VGA_RSTn !== 1'b1) low++;
        end
        n_checks++; if (low !== 0) begin n_fail++; $display("FAIL rst_no_residual: %0d low cycles want 0", low); end
    endtask

    initial begin
        test_reset;
        test_enable;
        test_single_recovery;
        test_regs;
        test_retry_exhaust;
        test_fault_clear;
        test_clr_priority;
        test_en_abort;
        test_reset_mid_hold;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_dls_recovery_ctrl.md
VGA_DLS_RECOVERY_CTRL -- requirements
Module: vga_dls_recovery_ctrl

Interface
REQ-001 Parameter MAX_RETRY, default 3: recoveries allowed before a permanent fault; range 1..15.
REQ-002 Parameter RESYNC_CYCLES, default 16: number of cycles VGA_RSTn is held low per recovery; range 2..255.
REQ-003 Clock and reset SHALL be: HCLK input 1, system clock; HRESETn input 1, reset, asynchronous, active-low.
REQ-004 AHB slave inputs SHALL be: HSEL 1, HADDR 32, HTRANS 2, HWRITE 1, HREADY 1, HWDATA 32.
REQ-005 AHB slave outputs SHALL be: HRDATA 32; HREADYOUT 1, tied to 1 (zero wait states).
REQ-006 DLS_ERROR input 1: registered mismatch flag from the lockstep VGA pair.
REQ-007 VGA_RSTn output 1: active-low reset to both VGA instances, ANDed externally with HRESETn.
REQ-008 FAULT output 1: permanent lockstep failure.
REQ-009 IRQ output 1: fault interrupt, see Configuration.

Function
REQ-010 Address phase SHALL be latched when HSEL & HREADY & HTRANS[1]; the write SHALL take effect at the end of the data phase, using HADDR[3:2].
REQ-011 Register 0x0 STATUS (read-only) SHALL read: [2:0] state, [3] FAULT, [4] IRQ pending, [11:8] retry_cnt, [23:16] err_total.
REQ-012 Register 0x4 CTRL SHALL provide: [0] EN (read/write, reset 0); [1] CLR (write-1 pulse, reads 0).
REQ-013 Reads of any other address SHALL return 0; writes to any other address SHALL be ignored.
REQ-014 FSM states and encodings: IDLE=0, RUN=1, HOLD=2, SETTLE=3, FAULT=4.
REQ-015 IDLE SHALL go to RUN on the cycle after EN=1; DLS_ERROR is ignored in IDLE.
REQ-016 RUN SHALL act on DLS_ERROR=1:
- err_total increments, saturating at 255.
- If retry_cnt==MAX_RETRY, next state is FAULT.
- Otherwise retry_cnt increments and next state is HOLD.
REQ-017 HOLD SHALL drive VGA_RSTn=0 for exactly RESYNC_CYCLES cycles, then go to SETTLE.
REQ-018 SETTLE SHALL last exactly 2 cycles, ignoring DLS_ERROR (flushes the comparator pipeline), then go to RUN.
REQ-019 FAULT SHALL hold VGA_RSTn=0 and FAULT=1 until a CLR write; EN=0 SHALL NOT exit FAULT.
REQ-020 A CLR write SHALL, on the next cycle:
- Set state to IDLE.
- Zero retry_cnt, err_total and IRQ pending.
- Leave EN unchanged.
REQ-021 EN=0 in RUN, HOLD or SETTLE SHALL force IDLE on the next cycle, with VGA_RSTn=1 and counters retained.
REQ-022 Priority SHALL be, highest first: CLR, then EN=0, then DLS_ERROR.
REQ-023 VGA_RSTn SHALL be 1 in IDLE, RUN and SETTLE.
REQ-024 FAULT SHALL be registered and equal (state==FAULT).
REQ-025 Counter widths: retry_cnt 4 bits, err_total 8 bits, hold counter 8 bits.

Reset
REQ-026 HRESETn low SHALL asynchronously set:
- state to IDLE, EN to 0, all counters to 0.
- VGA_RSTn=1, FAULT=0, IRQ=0.
- latched address phase cleared, HRDATA=0.
REQ-027 Reset asserted mid-HOLD SHALL abort the recovery immediately, with no residual VGA_RSTn pulse after release.

Configuration
REQ-028 Macro DLS_IRQ_EN defined:
- IRQ pending SHALL set on entry to FAULT and stay sticky until CLR.
- IRQ output SHALL equal IRQ pending.
REQ-029 Macro DLS_IRQ_EN undefined: the IRQ port SHALL remain present, tied 0, and STATUS[4] SHALL read 0.

Verification
REQ-030 Reset, write CTRL=0x1, read STATUS -> state=1, FAULT=0, VGA_RSTn=1.
REQ-031 In RUN, pulse DLS_ERROR for 1 cycle -> next cycle state=2, VGA_RSTn low for exactly 16 cycles, then SETTLE for 2 cycles, then RUN; STATUS shows retry_cnt=1, err_total=1.
REQ-032 Hold DLS_ERROR=1 continuously (MAX_RETRY=3) -> three recoveries occur, then the 4th error gives FAULT=1, state=4, VGA_RSTn=0; IRQ=1 with DLS_IRQ_EN, IRQ=0 without.
REQ-033 In FAULT, write CTRL=0x0 -> state stays 4; then write CTRL=0x3 (EN+CLR) -> IDLE, counters 0, then RUN on the following cycle.
REQ-034 Assert DLS_ERROR in the same cycle as a CLR write while in RUN -> state=IDLE and err_total=0.
REQ-035 Assert HRESETn low at HOLD cycle 5 -> VGA_RSTn=1 immediately; after release, state=0 and all counters read 0.
